// File: rtl/axis_uart_pkg.sv
// axis_uart_pkg
// Shared definitions for the axis_uart core and its command sequencer:
//   - host command codes (DIVIDER_CMD .. RX_DATA_CMD)
//   - register layouts for the clock divider and control registers
//   - command sequencer FSM state encoding and the error response byte
//   - is_write_cmd(): true for commands that carry a 4-byte payload
package axis_uart_pkg;

  // Host command codes (first byte of every frame)
  localparam logic [7:0] DIVIDER_CMD = 8'd1;
  localparam logic [7:0] CONTROL_CMD = 8'd2;
  localparam logic [7:0] TX_DATA_CMD = 8'd3;
  localparam logic [7:0] RX_DATA_CMD = 8'd4;

  // Response byte returned for an unrecognised command byte when the
  // error-response build option is enabled
  localparam logic [7:0] CMD_ERR_BYTE = 8'hEE;

  // UART control register layout; reserved bits always read as zero
  typedef struct packed {
    logic [27:0] reserved;
    logic        parity_even;
    logic        parity_odd;
    logic        tx_reset;
    logic        rx_reset;
  } uart_control_reg_t;

  // UART clock divider register (system clocks per bit)
  typedef logic [31:0] uart_clk_divider_reg_t;

  // Command sequencer states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    EXEC    = 2'd2,
    RESP    = 2'd3
  } cmd_state_e;

  // Commands followed by a 4-byte little-endian payload
  function automatic logic is_write_cmd(input logic [7:0] cmd);
    return (cmd == DIVIDER_CMD) || (cmd == CONTROL_CMD) || (cmd == TX_DATA_CMD);
  endfunction

endpackage

// File: rtl/axis_uart_cmd_ctrl_if.sv
// axis_uart_cmd_ctrl_if
// Bundles the four byte streams around the command sequencer:
//   s_cmd_*  host -> sequencer command bytes (valid/ready)
//   m_rsp_*  sequencer -> host response bytes (valid/ready)
//   m_tx_*   sequencer -> UART core TX bytes (valid/ready)
//   s_rx_*   UART core -> sequencer RX bytes (valid only, always accepted)
// Modports:
//   slave  : the sequencer's view (consumes cmd/rx, produces rsp/tx)
//   master : the environment's view (host plus UART core)
interface axis_uart_cmd_ctrl_if;

  logic [7:0] s_cmd_tdata;
  logic       s_cmd_tvalid;
  logic       s_cmd_tready;

  logic [7:0] m_rsp_tdata;
  logic       m_rsp_tvalid;
  logic       m_rsp_tready;

  logic [7:0] m_tx_tdata;
  logic       m_tx_tvalid;
  logic       m_tx_tready;

  logic [7:0] s_rx_tdata;
  logic       s_rx_tvalid;

  modport slave (
    input  s_cmd_tdata, s_cmd_tvalid,
    output s_cmd_tready,
    output m_rsp_tdata, m_rsp_tvalid,
    input  m_rsp_tready,
    output m_tx_tdata, m_tx_tvalid,
    input  m_tx_tready,
    input  s_rx_tdata, s_rx_tvalid
  );

  modport master (
    output s_cmd_tdata, s_cmd_tvalid,
    input  s_cmd_tready,
    input  m_rsp_tdata, m_rsp_tvalid,
    output m_rsp_tready,
    input  m_tx_tdata, m_tx_tvalid,
    output m_tx_tready,
    output s_rx_tdata, s_rx_tvalid
  );

endinterface

// File: rtl/axis_uart_cmd_ctrl.sv
// axis_uart_cmd_ctrl
// Command sequencer for one axis_uart core. Parses framed host commands
// (command byte, then 4 little-endian payload bytes for divider/control/TX
// writes; no payload for RX read), holds the divider and control registers,
// forwards TX bytes to the core and returns the last captured RX byte.
//
// Ports:
//   clk_i          single clock, rising edge
//   arstn_i        asynchronous active-low reset
//   bus            axis_uart_cmd_ctrl_if.slave (cmd, rsp, tx, rx streams)
//   clk_divider_o  divider register (reset DEFAULT_DIVIDER)
//   control_o      control register (uart_control_reg_t layout)
//
// Build option AXIS_UART_CMD_ERR_EN: when defined, an unknown command byte
// produces a CMD_ERR_BYTE response so the host can resynchronise; when
// undefined, unknown command bytes are silently dropped.
module axis_uart_cmd_ctrl
  import axis_uart_pkg::*;
#(
  parameter logic [31:0] DEFAULT_DIVIDER = 32'd868
) (
  input  logic                    clk_i,
  input  logic                    arstn_i,
  axis_uart_cmd_ctrl_if.slave     bus,
  output uart_clk_divider_reg_t   clk_divider_o,
  output uart_control_reg_t       control_o
);

  cmd_state_e            state_q;
  logic [7:0]            cmd_q;
  logic [1:0]            cnt_q;
  logic [31:0]           payload_q;
  uart_clk_divider_reg_t div_q;
  uart_control_reg_t     ctrl_q;
  logic                  tx_valid_q;
  logic [7:0]            tx_data_q;
  logic                  rsp_valid_q;
  logic [7:0]            rsp_data_q;
  logic                  ready_en_q;
  logic [7:0]            rx_data_q;
  logic                  rx_pending;
  logic                  rsp_err_q;

  logic cmd_hs;
  logic rsp_hs;
  logic tx_hs;

  // ready_en_q keeps the command port closed while reset is asserted and
  // opens it from the first clock after release
  assign bus.s_cmd_tready = ready_en_q && ((state_q == IDLE) || (state_q == PAYLOAD));
  assign bus.m_rsp_tvalid = rsp_valid_q;
  assign bus.m_rsp_tdata  = rsp_data_q;
  assign bus.m_tx_tvalid  = tx_valid_q;
  assign bus.m_tx_tdata   = tx_data_q;
  assign clk_divider_o    = div_q;
  assign control_o        = ctrl_q;

  assign cmd_hs = bus.s_cmd_tvalid && bus.s_cmd_tready;
  assign rsp_hs = rsp_valid_q && bus.m_rsp_tready;
  assign tx_hs  = tx_valid_q && bus.m_tx_tready;

`ifndef AXIS_UART_CMD_ERR_EN
  // Without error responses every response is an RX read
  assign rsp_err_q = 1'b0;
`endif

  // RX capture runs regardless of the sequencer state; the newest byte
  // always wins. An arriving byte keeps rx_pending set even when it lands
  // on the same edge as the response that consumes the previous one.
  // Error responses carry no RX data and leave rx_pending alone.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      rx_data_q  <= 8'h00;
      rx_pending <= 1'b0;
    end else begin
      if (bus.s_rx_tvalid) begin
        rx_data_q  <= bus.s_rx_tdata;
        rx_pending <= 1'b1;
      end else if (rsp_hs && !rsp_err_q) begin
        rx_pending <= 1'b0;
      end
    end
  end

  // Command sequencer. Output valids are registered so TX/RSP valid rise the
  // cycle after the frame's last handshake and drop immediately on reset.
  // The response byte is frozen on RESP entry so tdata is stable while
  // valid; a byte arriving on that same edge is forwarded directly.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q     <= IDLE;
      cmd_q       <= 8'h00;
      cnt_q       <= 2'd0;
      payload_q   <= 32'h0;
      div_q       <= DEFAULT_DIVIDER;
      ctrl_q      <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      ready_en_q  <= 1'b0;
`ifdef AXIS_UART_CMD_ERR_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      ready_en_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (cmd_hs) begin
            cmd_q <= bus.s_cmd_tdata;
            cnt_q <= 2'd0;
            if (is_write_cmd(bus.s_cmd_tdata)) begin
              state_q <= PAYLOAD;
            end else if (bus.s_cmd_tdata == RX_DATA_CMD) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= bus.s_rx_tvalid ? bus.s_rx_tdata : rx_data_q;
`ifdef AXIS_UART_CMD_ERR_EN
              rsp_err_q   <= 1'b0;
`endif
            end else begin
`ifdef AXIS_UART_CMD_ERR_EN
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= CMD_ERR_BYTE;
              rsp_err_q   <= 1'b1;
`else
              state_q     <= IDLE;
`endif
            end
          end
        end

        PAYLOAD: begin
          if (cmd_hs) begin
            payload_q[{cnt_q, 3'b000} +: 8] <= bus.s_cmd_tdata;
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              state_q <= EXEC;
              // Byte 0 of the payload was stored three handshakes ago
              if (cmd_q == TX_DATA_CMD) begin
                tx_valid_q <= 1'b1;
                tx_data_q  <= payload_q[7:0];
              end
            end
          end
        end

        EXEC: begin
          case (cmd_q)
            DIVIDER_CMD: begin
              // A zero divider would stall the UART; keep the old value
              if (payload_q != 32'h0) begin
                div_q <= payload_q;
              end
              state_q <= IDLE;
            end
            CONTROL_CMD: begin
              ctrl_q  <= uart_control_reg_t'({28'h0, payload_q[3:0]});
              state_q <= IDLE;
            end
            TX_DATA_CMD: begin
              if (tx_hs) begin
                tx_valid_q <= 1'b0;
                state_q    <= IDLE;
              end
            end
            default: begin
              state_q <= IDLE;
            end
          endcase
        end

        RESP: begin
          if (rsp_hs) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // A captured RX byte is always marked pending on the following cycle
  rx_pending_after_capture: assert property (
    @(posedge clk_i) disable iff (!arstn_i) bus.s_rx_tvalid |=> rx_pending
  );

endmodule

// File: tb/tb_axis_uart_cmd_ctrl.sv
// tb_axis_uart_cmd_ctrl
// Directed bench for axis_uart_cmd_ctrl: drives command frames byte by byte
// and compares registers and streams against hand-computed values.
// Follows the build option AXIS_UART_CMD_ERR_EN for unknown-command checks.
module tb_axis_uart_cmd_ctrl;
  import axis_uart_pkg::*;

  logic                  clk;
  logic                  arstn;
  uart_clk_divider_reg_t clk_divider;
  uart_control_reg_t     control;

  int num_compared;
  int num_mismatched;
  int tx_hs_count;

  axis_uart_cmd_ctrl_if bus ();

  axis_uart_cmd_ctrl #(
    .DEFAULT_DIVIDER(32'd868)
  ) dut (
    .clk_i        (clk),
    .arstn_i      (arstn),
    .bus          (bus.slave),
    .clk_divider_o(clk_divider),
    .control_o    (control)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count TX handshakes seen by the UART core side
  always @(posedge clk) begin
    if (bus.m_tx_tvalid && bus.m_tx_tready) begin
      tx_hs_count++;
    end
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    num_compared++;
    if (got !== exp) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one command byte and return just after its handshake edge
  task automatic applyStimulus(input logic [7:0] b);
    int waited;
    waited = 0;
    @(negedge clk);
    bus.s_cmd_tdata  = b;
    bus.s_cmd_tvalid = 1'b1;
    while (!bus.s_cmd_tready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.s_cmd_tready) begin
      checkOutput("cmd_ready_timeout", 32'd0, 32'd1);
    end
    @(posedge clk);
    #1;
    bus.s_cmd_tvalid = 1'b0;
  endtask

  // Pulse one RX byte from the UART core for a single cycle
  task automatic pulseRx(input logic [7:0] b);
    @(negedge clk);
    bus.s_rx_tdata  = b;
    bus.s_rx_tvalid = 1'b1;
    @(posedge clk);
    #1;
    bus.s_rx_tvalid = 1'b0;
  endtask

  task automatic sendFrame(input logic [7:0] cmd, input logic [31:0] payload);
    applyStimulus(cmd);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(payload[8*i +: 8]);
    end
  endtask

  initial begin
    num_compared   = 0;
    num_mismatched = 0;
    tx_hs_count    = 0;
    arstn            = 1'b0;
    bus.s_cmd_tdata  = 8'h00;
    bus.s_cmd_tvalid = 1'b0;
    bus.m_rsp_tready = 1'b0;
    bus.m_tx_tready  = 1'b0;
    bus.s_rx_tdata   = 8'h00;
    bus.s_rx_tvalid  = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rst_divider", clk_divider, 32'd868);
    checkOutput("rst_control", control, 32'h0);
    checkOutput("rst_tx_valid", {31'd0, bus.m_tx_tvalid}, 32'd0);
    checkOutput("rst_rsp_valid", {31'd0, bus.m_rsp_tvalid}, 32'd0);
    checkOutput("rst_tx_data", {24'd0, bus.m_tx_tdata}, 32'd0);
    checkOutput("rst_rsp_data", {24'd0, bus.m_rsp_tdata}, 32'd0);
    checkOutput("rst_cmd_ready", {31'd0, bus.s_cmd_tready}, 32'd0);
    arstn = 1'b1;
    #1;
    checkOutput("rel_cmd_ready_low", {31'd0, bus.s_cmd_tready}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("rel_cmd_ready_high", {31'd0, bus.s_cmd_tready}, 32'd1);

    // RX read after reset returns stale 0x00, held while host stalls
    applyStimulus(RX_DATA_CMD);
    checkOutput("rd0_valid", {31'd0, bus.m_rsp_tvalid}, 32'd1);
    checkOutput("rd0_data", {24'd0, bus.m_rsp_tdata}, 32'h00);
    checkOutput("rd0_cmd_ready", {31'd0, bus.s_cmd_tready}, 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput("rd0_hold_valid", {31'd0, bus.m_rsp_tvalid}, 32'd1);
    end
    @(negedge clk);
    bus.m_rsp_tready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rd0_drop_valid", {31'd0, bus.m_rsp_tvalid}, 32'd0);

    // Divider write: visible 2 cycles after the last payload byte
    sendFrame(DIVIDER_CMD, 32'h0000_01B2);
    checkOutput("div_not_yet", clk_divider, 32'd868);
    checkOutput("div_exec_not_ready", {31'd0, bus.s_cmd_tready}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("div_write", clk_divider, 32'h0000_01B2);
    checkOutput("div_ready_again", {31'd0, bus.s_cmd_tready}, 32'd1);

    // Zero divider is rejected
    sendFrame(DIVIDER_CMD, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("div_zero_reject", clk_divider, 32'h0000_01B2);

    // Control write masks reserved bits
    sendFrame(CONTROL_CMD, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    checkOutput("ctrl_write", control, 32'h0000_000F);

    // TX byte held through 5 stalled cycles, exactly one handshake
    bus.m_tx_tready = 1'b0;
    tx_hs_count     = 0;
    sendFrame(TX_DATA_CMD, 32'h0000_0041);
    checkOutput("tx_valid_rise", {31'd0, bus.m_tx_tvalid}, 32'd1);
    checkOutput("tx_data", {24'd0, bus.m_tx_tdata}, 32'h41);
    repeat (5) begin
      @(posedge clk);
      #1;
      checkOutput("tx_hold_valid", {31'd0, bus.m_tx_tvalid}, 32'd1);
      checkOutput("tx_hold_data", {24'd0, bus.m_tx_tdata}, 32'h41);
    end
    @(negedge clk);
    bus.m_tx_tready = 1'b1;
    @(posedge clk);
    #1;
    bus.m_tx_tready = 1'b0;
    checkOutput("tx_drop_valid", {31'd0, bus.m_tx_tvalid}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("tx_hs_count", tx_hs_count, 32'd1);

    // RX capture and read-back; a byte landing on the response handshake
    pulseRx(8'h5A);
    applyStimulus(RX_DATA_CMD);
    checkOutput("rd1_valid", {31'd0, bus.m_rsp_tvalid}, 32'd1);
    checkOutput("rd1_data", {24'd0, bus.m_rsp_tdata}, 32'h5A);
    bus.s_rx_tdata  = 8'h33;
    bus.s_rx_tvalid = 1'b1;
    @(posedge clk);
    #1;
    bus.s_rx_tvalid = 1'b0;
    checkOutput("rd1_drop_valid", {31'd0, bus.m_rsp_tvalid}, 32'd0);
    applyStimulus(RX_DATA_CMD);
    checkOutput("rd2_data", {24'd0, bus.m_rsp_tdata}, 32'h33);
    @(posedge clk);
    #1;

    // Unknown command byte
    applyStimulus(8'h07);
`ifdef AXIS_UART_CMD_ERR_EN
    checkOutput("unk_rsp_valid", {31'd0, bus.m_rsp_tvalid}, 32'd1);
    checkOutput("unk_rsp_data", {24'd0, bus.m_rsp_tdata}, 32'hEE);
    @(posedge clk);
    #1;
`else
    checkOutput("unk_no_rsp", {31'd0, bus.m_rsp_tvalid}, 32'd0);
    checkOutput("unk_ready", {31'd0, bus.s_cmd_tready}, 32'd1);
`endif
    sendFrame(CONTROL_CMD, 32'h0000_0001);
    @(posedge clk);
    #1;
    checkOutput("ctrl_after_unk", control, 32'h0000_0001);

    // Reset in the middle of a divider frame
    applyStimulus(DIVIDER_CMD);
    applyStimulus(8'hAA);
    applyStimulus(8'h55);
    @(negedge clk);
    arstn = 1'b0;
    #1;
    checkOutput("midrst_divider", clk_divider, 32'd868);
    checkOutput("midrst_control", control, 32'h0);
    @(negedge clk);
    arstn = 1'b1;
    sendFrame(CONTROL_CMD, 32'h0000_0005);
    @(posedge clk);
    #1;
    checkOutput("midrst_ctrl_frame", control, 32'h0000_0005);
    sendFrame(DIVIDER_CMD, 32'h0000_1234);
    @(posedge clk);
    #1;
    checkOutput("midrst_div_frame", clk_divider, 32'h0000_1234);

    // Reset while a TX byte is waiting drops the valid asynchronously
    bus.m_tx_tready = 1'b0;
    sendFrame(TX_DATA_CMD, 32'h0000_0077);
    checkOutput("txrst_valid_before", {31'd0, bus.m_tx_tvalid}, 32'd1);
    #2;
    arstn = 1'b0;
    #1;
    checkOutput("txrst_valid_drop", {31'd0, bus.m_tx_tvalid}, 32'd0);
    @(negedge clk);
    arstn = 1'b1;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
